// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TIME_W = 2;

    localparam logic [TIME_W-1:0] TUSE_D    = 2'd0;
    localparam logic [TIME_W-1:0] TUSE_E    = 2'd1;
    localparam logic [TIME_W-1:0] TUSE_NONE = 2'd3;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One source-vs-destination dependency check; $0 and unused operands never stall.
    function automatic logic src_hazard(
        input logic [REG_W-1:0]  src,
        input logic [TIME_W-1:0] tuse,
        input logic [REG_W-1:0]  dst,
        input logic              dst_en,
        input logic [TIME_W-1:0] tnew
    );
        return (src != '0) && (tuse != TUSE_NONE) && dst_en && (src == dst) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy timer: loads the op latency on start, counts down to idle.
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int unsigned MAX_CYC = max_u(MULT_CYCLES, DIV_CYCLES);
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    logic [CW-1:0] cnt;

    // A start always wins over the decrement so a reload restarts the full latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall / bubble / exception-flush controller with stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REG_W-1:0]   D_rs,
    input  logic [REG_W-1:0]   D_rt,
    input  logic [TIME_W-1:0]  D_rs_tuse,
    input  logic [TIME_W-1:0]  D_rt_tuse,
    input  logic [REG_W-1:0]   E_write_number,
    input  logic [REG_W-1:0]   M_write_number,
    input  logic               E_write_enable,
    input  logic               M_write_enable,
    input  logic [TIME_W-1:0]  E_tnew,
    input  logic [TIME_W-1:0]  M_tnew,
    input  logic               D_md_use,
    input  logic               E_md_start,
    input  logic               E_md_is_div,
    input  logic               exc_req,
    output logic               PC_en,
    output logic               FD_stall,
    output logic               DE_flush,
    output logic               req,
    output logic               md_busy,
    output logic [CNT_W-1:0]   stall_cycles
);

    logic reg_hazard;
    logic md_hazard;
    logic stall;
    logic md_start;

    // The E-stage op is younger than the excepting M op, so it must not start the timer.
    assign md_start = E_md_start && !exc_req;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_timer (
        .clk    (clk),
        .rst_n  (reset),
        .start  (md_start),
        .is_div (E_md_is_div),
        .busy   (md_busy)
    );

    always_comb begin
        reg_hazard = 1'b0;
        md_hazard  = 1'b0;
        reg_hazard = src_hazard(D_rs, D_rs_tuse, E_write_number, E_write_enable, E_tnew)
                  || src_hazard(D_rs, D_rs_tuse, M_write_number, M_write_enable, M_tnew)
                  || src_hazard(D_rt, D_rt_tuse, E_write_number, E_write_enable, E_tnew)
                  || src_hazard(D_rt, D_rt_tuse, M_write_number, M_write_enable, M_tnew);
        md_hazard  = D_md_use && (md_busy || E_md_start);
    end

    assign stall = reg_hazard || md_hazard;
    assign req   = exc_req;

    // req flushes every register itself, so it overrides any stall request.
    always_comb begin
        PC_en    = 1'b1;
        FD_stall = 1'b0;
        DE_flush = 1'b0;
        if (!exc_req && stall) begin
            PC_en    = 1'b0;
            FD_stall = 1'b1;
            DE_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall && !exc_req && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
